// File: rtl/terminal_requisicao_if.sv
// Request bus for one access terminal: raw user inputs in, latched request word and status out.
// The DUT uses the slave modport; the bench drives the master side.
interface terminal_requisicao_if;
    logic [2:0] sw_id;
    logic [2:0] sw_f;
    logic       btn_send;
    logic       btn_cancel;
    logic       req_ack;
    logic [3:0] hh;
    logic [1:0] b;
    logic       req_valid;
    logic       busy;
    logic       err;
    logic [1:0] state;

    modport slave (
        input  sw_id, sw_f, btn_send, btn_cancel, req_ack,
        output hh, b, req_valid, busy, err, state
    );

    modport master (
        output sw_id, sw_f, btn_send, btn_cancel, req_ack,
        input  hh, b, req_valid, busy, err, state
    );
endinterface

// File: rtl/terminal_requisicao.sv
// Terminal front end: debounces SEND/CANCEL, latches {HH,B} on SEND and offers it
// with valid/ack plus timeout, then holds the accepted word for a display interval.
module terminal_requisicao #(
    parameter int DEB_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int HOLD_CYCLES    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    terminal_requisicao_if.slave  bus
);

    localparam logic [15:0] DEB_LAST     = 16'(DEB_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } state_t;

    logic [1:0] raw;
    logic [1:0] press;
    logic       send_press;
    logic       cancel_press;

    assign raw = {bus.btn_cancel, bus.btn_send};

    // Index 0 is SEND, index 1 is CANCEL; both share the same debounce path.
    // press_reg is set together with the debounced level, so it lands one edge later in the FSM.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic        sync1_reg;
            logic        sync2_reg;
            logic        level_reg;
            logic        press_reg;
            logic [15:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        level_reg <= sync2_reg;
                        press_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    assign send_press   = press[0];
    assign cancel_press = press[1];

    state_t      state_reg;
    logic [3:0]  hh_reg;
    logic [1:0]  b_reg;
    logic        valid_reg;
    logic        busy_reg;
    logic        err_reg;
    logic [15:0] cnt_reg;

    // Within REQ the branch order encodes priority: cancel, ack, timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            hh_reg    <= '0;
            b_reg     <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (send_press) begin
                        if (bus.sw_id != 3'b000) begin
                            hh_reg    <= {bus.sw_f[0], bus.sw_id};
                            b_reg     <= bus.sw_f[2:1];
                            err_reg   <= 1'b0;
                            valid_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= REQ;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (cancel_press) begin
                        state_reg <= IDLE;
                        hh_reg    <= '0;
                        b_reg     <= '0;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else if (bus.req_ack) begin
                        state_reg <= HOLD;
                        valid_reg <= 1'b0;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg <= IDLE;
                        hh_reg    <= '0;
                        b_reg     <= '0;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        err_reg   <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                HOLD: begin
                    if (cancel_press || cnt_reg == HOLD_LAST) begin
                        state_reg <= IDLE;
                        hh_reg    <= '0;
                        b_reg     <= '0;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    hh_reg    <= '0;
                    b_reg     <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.hh        = hh_reg;
    assign bus.b         = b_reg;
    assign bus.req_valid = valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.err       = err_reg;
    assign bus.state     = state_reg;

endmodule

// File: tb/tb_terminal_requisicao.sv
// Scoreboard bench for terminal_requisicao (DEB=4, TIMEOUT=8, HOLD=5): stimulus pushes each
// expected output change; the monitor pops one entry whenever the DUT's outputs change.
module tb_terminal_requisicao;

    localparam int DEB = 4;
    localparam int TO  = 8;
    localparam int HLD = 5;

    typedef struct {
        logic [10:0] snap;   // {state, hh, b, req_valid, busy, err}
        int          dwell;  // negedge samples since the previous change; -1 = don't care
        int          tag;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    terminal_requisicao_if bus ();

    terminal_requisicao #(
        .DEB_CYCLES    (DEB),
        .TIMEOUT_CYCLES(TO),
        .HOLD_CYCLES   (HLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] snap_now();
        return {bus.state, bus.hh, bus.b, bus.req_valid, bus.busy, bus.err};
    endfunction

    function automatic exp_t mk(input logic [1:0] st, input logic [3:0] hh, input logic [1:0] b,
                                input logic v, input logic bsy, input logic e,
                                input int dwell, input int tag);
        exp_t x;
        x.snap  = {st, hh, b, v, bsy, e};
        x.dwell = dwell;
        x.tag   = tag;
        return x;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_direct(input string name, input logic [10:0] want);
        logic [10:0] got;
        got = snap_now();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got snap=%h want snap=%h", name, got, want);
        end else begin
            $display("ok %s: snap=%h", name, got);
        end
    endtask

    // Monitor: every change of the observable outputs is one transaction.
    initial begin : monitor
        logic [10:0] last;
        logic [10:0] cur;
        int          dwell;
        exp_t        e;
        last  = '0;
        dwell = 0;
        forever begin
            @(negedge clk);
            cur = snap_now();
            if (rst) begin
                last  = cur;
                dwell = 0;
            end else begin
                dwell++;
                if (cur !== last) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event: got snap=%h dwell=%0d, no change expected",
                                 cur, dwell);
                    end else begin
                        e = sb.pop_front();
                        if (cur !== e.snap || (e.dwell >= 0 && dwell != e.dwell)) begin
                            failures++;
                            $display("FAIL event_%0d: got snap=%h dwell=%0d, want snap=%h dwell=%0d",
                                     e.tag, cur, dwell, e.snap, e.dwell);
                        end else begin
                            $display("ok event_%0d: snap=%h dwell=%0d", e.tag, cur, dwell);
                        end
                    end
                    last  = cur;
                    dwell = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst            = 1'b1;
        bus.sw_id      = 3'b000;
        bus.sw_f       = 3'b000;
        bus.btn_send   = 1'b0;
        bus.btn_cancel = 1'b0;
        bus.req_ack    = 1'b0;
        tick(3);
        check_direct("reset_state", 11'h000);
        rst = 1'b0;
        tick(3);

        // 1: basic handshake, ack on 3rd valid cycle, switch change in HOLD ignored
        bus.sw_id = 3'b101;
        bus.sw_f  = 3'b110;
        sb.push_back(mk(2'b01, 4'b0101, 2'b11, 1'b1, 1'b1, 1'b0, -1, 1));
        sb.push_back(mk(2'b10, 4'b0101, 2'b11, 1'b0, 1'b1, 1'b0, 3, 2));
        sb.push_back(mk(2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, HLD, 3));
        bus.btn_send = 1'b1;
        tick(9);
        bus.req_ack = 1'b1;
        tick(1);
        bus.req_ack  = 1'b0;
        bus.btn_send = 1'b0;
        bus.sw_id    = 3'b010;
        bus.sw_f     = 3'b001;
        tick(12);

        // 2: 3-cycle glitch must produce nothing
        bus.btn_send = 1'b1;
        tick(3);
        bus.btn_send = 1'b0;
        tick(10);

        // 3: timeout sets ERR, then a valid SEND clears it; cancel ends that request
        bus.sw_id = 3'b011;
        bus.sw_f  = 3'b000;
        sb.push_back(mk(2'b01, 4'b0011, 2'b00, 1'b1, 1'b1, 1'b0, -1, 4));
        sb.push_back(mk(2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, TO, 5));
        bus.btn_send = 1'b1;
        tick(8);
        bus.btn_send = 1'b0;
        tick(20);
        bus.sw_id = 3'b110;
        bus.sw_f  = 3'b001;
        sb.push_back(mk(2'b01, 4'b1110, 2'b00, 1'b1, 1'b1, 1'b0, -1, 6));
        sb.push_back(mk(2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 6, 7));
        bus.btn_send = 1'b1;
        tick(6);
        bus.btn_send   = 1'b0;
        bus.btn_cancel = 1'b1;
        tick(8);
        bus.btn_cancel = 1'b0;
        tick(15);

        // 4: invalid id sets ERR only; CANCEL in IDLE does nothing
        bus.sw_id = 3'b000;
        bus.sw_f  = 3'b111;
        sb.push_back(mk(2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, -1, 8));
        bus.btn_send = 1'b1;
        tick(8);
        bus.btn_send = 1'b0;
        tick(10);
        bus.btn_cancel = 1'b1;
        tick(8);
        bus.btn_cancel = 1'b0;
        tick(10);

        // 5: ack and cancel press on the same REQ cycle -> IDLE; ack held in IDLE ignored
        bus.sw_id = 3'b001;
        bus.sw_f  = 3'b010;
        sb.push_back(mk(2'b01, 4'b0001, 2'b01, 1'b1, 1'b1, 1'b0, -1, 9));
        sb.push_back(mk(2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2, 10));
        bus.btn_send = 1'b1;
        tick(2);
        bus.btn_cancel = 1'b1;
        tick(6);
        bus.req_ack = 1'b1;
        tick(1);
        bus.btn_send   = 1'b0;
        bus.btn_cancel = 1'b0;
        tick(15);
        tick(5);
        bus.req_ack = 1'b0;

        // 6: ack on the last timeout cycle wins -> HOLD without ERR
        bus.sw_id = 3'b100;
        bus.sw_f  = 3'b100;
        sb.push_back(mk(2'b01, 4'b0100, 2'b10, 1'b1, 1'b1, 1'b0, -1, 11));
        sb.push_back(mk(2'b10, 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0, TO, 12));
        sb.push_back(mk(2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, HLD, 13));
        bus.btn_send = 1'b1;
        tick(8);
        bus.btn_send = 1'b0;
        bus.sw_id    = 3'b111;
        tick(6);
        bus.req_ack = 1'b1;
        tick(1);
        bus.req_ack = 1'b0;
        bus.sw_f    = 3'b011;
        tick(12);

        // 7: async reset mid-HOLD, then a held SEND gives REQ_VALID DEB+2 edges after release
        bus.sw_id = 3'b111;
        bus.sw_f  = 3'b011;
        sb.push_back(mk(2'b01, 4'b1111, 2'b01, 1'b1, 1'b1, 1'b0, -1, 14));
        sb.push_back(mk(2'b10, 4'b1111, 2'b01, 1'b0, 1'b1, 1'b0, 1, 15));
        bus.btn_send = 1'b1;
        tick(7);
        bus.req_ack = 1'b1;
        tick(1);
        bus.req_ack = 1'b0;
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        check_direct("async_reset", 11'h000);
        tick(2);
        // samples after edges 0..DEB+2 => DEB+3 samples since release
        sb.push_back(mk(2'b01, 4'b1111, 2'b01, 1'b1, 1'b1, 1'b0, DEB + 3, 16));
        sb.push_back(mk(2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 7, 17));
        rst = 1'b0;
        tick(7);
        bus.btn_send   = 1'b0;
        bus.btn_cancel = 1'b1;
        tick(8);
        bus.btn_cancel = 1'b0;
        tick(15);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending events, want 0", sb.size());
        end else begin
            $display("ok scoreboard_drain: 0 pending");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/terminal_requisicao.md
Name: terminal_requisicao

Overview:
- Sequential front end for one access terminal. Turns raw switch and push-button inputs into a stable request word {HH[3:0], B[1:0]} for the combinational access-control core, which decodes it into LEDs, matrix and 7-seg.
- Debounces the buttons, latches the request on a SEND press, and offers it with a valid/ack handshake plus timeout.
- Holds the accepted word for a display interval, then clears it.
- Two instances are used, one per terminal (HH0/B0 and HH1/B1).

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronized cycles needed to change a debounced button level. Range 1..65535.
- TIMEOUT_CYCLES, 255: maximum cycles REQ_VALID stays high without REQ_ACK. Range 1..65535.
- HOLD_CYCLES, 1000: cycles the accepted word is held after ack. Range 1..65535.

Ports:
- CLK, input, 1: single clock, rising edge.
- RST, input, 1: asynchronous, active-high reset.
- SW_ID, input, 3: user permission/id switches; maps to HH[2:0].
- SW_F, input, 3: functionality switches; SW_F[0] maps to HH[3], SW_F[2:1] map to B[1:0].
- BTN_SEND, input, 1: raw send button, active-high, asynchronous to CLK.
- BTN_CANCEL, input, 1: raw cancel button, active-high, asynchronous to CLK.
- REQ_ACK, input, 1: consumer accepted the word; sampled only in state REQ.
- HH, output, 4: latched request bits to the core.
- B, output, 2: latched function bits to the core.
- REQ_VALID, output, 1: request offered.
- BUSY, output, 1: state is not IDLE.
- ERR, output, 1: sticky error flag.
- STATE, output, 2: IDLE=00, REQ=01, HOLD=10 (debug).

Behaviour:
- Reset (async, RST=1):
  - State IDLE; HH=0, B=0, REQ_VALID=0, BUSY=0, ERR=0, STATE=00.
  - Synchronizers, debounced levels and all counters are 0.
  - Reset mid-operation aborts immediately; no ack or hold completion is owed.
- Button path, identical for SEND and CANCEL:
  - 2-flop synchronizer, then a 16-bit debounce counter.
  - The counter increments while sync != debounced and clears when they are equal.
  - When the counter equals DEB_CYCLES-1 and sync still differs, the debounced level toggles and the counter clears.
  - A one-cycle press pulse is generated on the rising edge of the debounced level.
  - A raw pulse shorter than DEB_CYCLES synchronized cycles produces no press.
  - Release generates nothing.
  - Latency: for a raw input high before edge 0 and held, REQ_VALID is high after edge DEB_CYCLES+2.
- FSM, all outputs registered. Priority within a cycle: CANCEL press > REQ_ACK > timeout > SEND press.
- IDLE:
  - HH=0, B=0, REQ_VALID=0.
  - On SEND press with SW_ID != 000: latch HH={SW_F[0],SW_ID}, B=SW_F[2:1]; clear ERR; go to REQ.
  - On SEND press with SW_ID == 000: set ERR, stay in IDLE, outputs unchanged.
  - CANCEL press in IDLE: no effect.
- REQ:
  - REQ_VALID=1; HH/B frozen, switch changes ignored.
  - A 16-bit counter counts cycles in REQ, starting at 0 on entry.
  - REQ_ACK=1: go to HOLD, REQ_VALID=0 next cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: set ERR, clear HH/B, go to IDLE. REQ_VALID is therefore high exactly TIMEOUT_CYCLES cycles.
  - REQ_ACK on the final timeout cycle: ack wins, no ERR.
  - CANCEL press: go to IDLE, clear HH/B, no ERR.
  - SEND press: ignored.
- HOLD:
  - REQ_VALID=0; HH/B still driven, frozen.
  - Counter runs from 0; after HOLD_CYCLES cycles in HOLD, clear HH/B and go to IDLE.
  - CANCEL press: immediate return to IDLE, HH/B cleared.
  - SEND press and REQ_ACK: ignored.
- REQ_ACK held high continuously: it is acted on only on the REQ cycle; it has no effect in IDLE or HOLD.
- BUSY = (STATE != IDLE), registered alongside STATE.
- ERR stays set until RST or the next accepted SEND press (one with SW_ID != 000).

Test Plan:
- Basic handshake (DEB=4, TIMEOUT=8, HOLD=5):
  - Stimulus: SW_ID=101, SW_F=110; BTN_SEND high for 10 cycles; REQ_ACK pulsed on the 3rd REQ_VALID cycle.
  - Response: REQ_VALID rises after edge 6; HH=0101, B=11 while valid. After ack, REQ_VALID=0 and STATE=10. HH/B held 5 cycles, then 0000/00 and STATE=00.
- Glitch rejection:
  - Stimulus: BTN_SEND high for 3 cycles (DEB=4).
  - Response: no press; STATE stays 00; HH=0.
- Timeout:
  - Stimulus: valid press, no REQ_ACK.
  - Response: REQ_VALID high exactly 8 cycles; then ERR=1, HH=0, STATE=00.
  - Follow-up: the next valid SEND press clears ERR.
- Invalid id:
  - Stimulus: SW_ID=000 with a SEND press.
  - Response: ERR=1, REQ_VALID stays 0, STATE=00.
- Simultaneous events:
  - REQ_ACK and CANCEL press in the same REQ cycle: result is IDLE, HH=0.
  - REQ_ACK on the 8th (last) timeout cycle: result is HOLD, ERR=0.
  - Switch changes during REQ/HOLD: HH/B unchanged.
- Async reset:
  - Stimulus: RST asserted mid-HOLD, between clock edges.
  - Response: all outputs go to 0 without waiting for a clock edge. After release, a BTN_SEND already held high yields REQ_VALID exactly DEB+2 edges later.
